scr1_dm_abs_regs: RTL and testbench

DMI responder for the Debug Module's abstract-command register group. It serves DMI reads and writes for data0/data1, abstractcs, command, abstractauto and progbuf0..N-1. Each DMI request is acknowledged in the same cycle it is issued. The block launches abstract commands toward the hart-side debug agent through a req/ack/done handshake. It sits on the DM side of the DMI link, between the DTM's DMI initiator and the hart debug logic.

---
 rtl/scr1_dm_abs_regs.sv | 179 +++++++++++++++++
 tb/tb_scr1_dm_abs_regs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scr1_dm_abs_regs.sv
// rtl/scr1_dm_abs_regs.sv - Debug Module abstract-command register group (DMI responder)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   dmi2dm_*                DMI request (req pulse, wr, 7-bit addr, 32-bit wdata)
//   dm2dmi_resp_o/rdata_o   same-cycle combinational response and read data
//   cmd_req_o/cmd_o         abstract command launch toward the hart agent
//   cmd_ack_i/done_i/err_i  hart agent handshake and completion status
//   hart_data_*             hart-side writes into data0/data1 while busy
//   data0_o/data1_o         current data register values
//   progbuf_o               flattened program buffer, word 0 in the LSBs
module scr1_dm_abs_regs #(
    parameter int PROGBUF_SIZE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dmi2dm_req_i,
    input  logic                      dmi2dm_wr_i,
    input  logic [6:0]                dmi2dm_addr_i,
    input  logic [31:0]               dmi2dm_wdata_i,
    output logic                      dm2dmi_resp_o,
    output logic [31:0]               dm2dmi_rdata_o,
    output logic                      cmd_req_o,
    output logic [31:0]               cmd_o,
    input  logic                      cmd_ack_i,
    input  logic                      cmd_done_i,
    input  logic                      cmd_err_i,
    input  logic                      hart_data_we_i,
    input  logic                      hart_data_sel_i,
    input  logic [31:0]               hart_data_i,
    output logic [31:0]               data0_o,
    output logic [31:0]               data1_o,
    output logic [32*PROGBUF_SIZE-1:0] progbuf_o
);

    localparam logic [6:0] ADDR_DATA0    = 7'h04;
    localparam logic [6:0] ADDR_DATA1    = 7'h05;
    localparam logic [6:0] ADDR_ABSCS    = 7'h16;
    localparam logic [6:0] ADDR_COMMAND  = 7'h17;
    localparam logic [6:0] ADDR_ABSAUTO  = 7'h18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_cmd_req;
    logic [31:0] r_cmd;
    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic [1:0]  r_autoexec;
    logic [2:0]  r_cmderr;
    logic [31:0] r_progbuf [PROGBUF_SIZE];

    logic        w_busy;
    logic        w_sel_data0;
    logic        w_sel_data1;
    logic        w_sel_abscs;
    logic        w_sel_cmd;
    logic        w_sel_auto;
    logic        w_sel_pb;
    logic [3:0]  w_pb_idx;
    logic        w_wr;
    logic        w_busy_err;
    logic        w_can_launch;
    logic        w_launch_cmd;
    logic        w_launch_auto;
    logic        w_done_take;
    logic [31:0] w_rdata;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_sel_data0 = (dmi2dm_addr_i == ADDR_DATA0);
    assign w_sel_data1 = (dmi2dm_addr_i == ADDR_DATA1);
    assign w_sel_abscs = (dmi2dm_addr_i == ADDR_ABSCS);
    assign w_sel_cmd   = (dmi2dm_addr_i == ADDR_COMMAND);
    assign w_sel_auto  = (dmi2dm_addr_i == ADDR_ABSAUTO);
    assign w_pb_idx    = dmi2dm_addr_i[3:0];
    assign w_sel_pb    = (dmi2dm_addr_i[6:4] == 3'b010) &&
                         ({1'b0, w_pb_idx} < 5'(PROGBUF_SIZE));
    assign w_wr        = dmi2dm_req_i & dmi2dm_wr_i;

    // Any access (read or write) to a register the running command may use is an error.
    assign w_busy_err  = dmi2dm_req_i & w_busy &
                         (w_sel_data0 | w_sel_data1 | w_sel_cmd | w_sel_auto | w_sel_pb);

    assign w_can_launch  = ~w_busy & (r_cmderr == 3'd0);
    assign w_launch_cmd  = w_wr & w_sel_cmd & w_can_launch;
    assign w_launch_auto = dmi2dm_req_i & w_can_launch &
                           ((w_sel_data0 & r_autoexec[0]) | (w_sel_data1 & r_autoexec[1]));

    // Completion is only accepted once the command has been acknowledged.
    assign w_done_take = cmd_done_i &
                         (((r_state == ST_REQ) & cmd_ack_i) | (r_state == ST_WAIT));

    always_comb begin
        w_rdata = 32'h0;
        if (w_sel_data0) w_rdata = r_data0;
        if (w_sel_data1) w_rdata = r_data1;
        if (w_sel_abscs) w_rdata = {3'b0, 5'(PROGBUF_SIZE), 11'b0, w_busy, 1'b0, r_cmderr, 4'b0, 4'd2};
        if (w_sel_auto)  w_rdata = {30'b0, r_autoexec};
        for (int i = 0; i < PROGBUF_SIZE; i++) begin
            if (w_sel_pb && (w_pb_idx == 4'(i))) w_rdata = r_progbuf[i];
        end
    end

    assign dm2dmi_resp_o  = dmi2dm_req_i;
    assign dm2dmi_rdata_o = dmi2dm_req_i ? w_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmd_req  <= 1'b0;
            r_cmd      <= 32'h0;
            r_data0    <= 32'h0;
            r_data1    <= 32'h0;
            r_autoexec <= 2'b00;
            r_cmderr   <= 3'd0;
            for (int i = 0; i < PROGBUF_SIZE; i++) r_progbuf[i] <= 32'h0;
        end else begin
            // DMI writes to command-visible state only land while idle;
            // hart writes only land while busy, so the two never collide.
            if (w_wr && !w_busy) begin
                if (w_sel_data0) r_data0 <= dmi2dm_wdata_i;
                if (w_sel_data1) r_data1 <= dmi2dm_wdata_i;
                if (w_sel_auto)  r_autoexec <= dmi2dm_wdata_i[1:0];
                for (int i = 0; i < PROGBUF_SIZE; i++) begin
                    if (w_sel_pb && (w_pb_idx == 4'(i))) r_progbuf[i] <= dmi2dm_wdata_i;
                end
            end
            if (hart_data_we_i && w_busy) begin
                if (hart_data_sel_i) r_data1 <= hart_data_i;
                else                 r_data0 <= hart_data_i;
            end
            if (w_launch_cmd) r_cmd <= dmi2dm_wdata_i;

            // Busy-access error outranks a simultaneous failing completion.
            if (w_busy_err && (r_cmderr == 3'd0))
                r_cmderr <= 3'd1;
            else if (w_done_take && cmd_err_i && (r_cmderr == 3'd0))
                r_cmderr <= 3'd3;
            else if (w_wr && w_sel_abscs)
                r_cmderr <= r_cmderr & ~dmi2dm_wdata_i[10:8];

            case (r_state)
                ST_IDLE: begin
                    if (w_launch_cmd || w_launch_auto) begin
                        r_state   <= ST_REQ;
                        r_cmd_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (cmd_ack_i) begin
                        r_cmd_req <= 1'b0;
                        r_state   <= cmd_done_i ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cmd_done_i) r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cmd_req <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_req_o = r_cmd_req;
    assign cmd_o     = r_cmd;
    assign data0_o   = r_data0;
    assign data1_o   = r_data1;

    for (genvar g = 0; g < PROGBUF_SIZE; g++) begin : g_pb_out
        assign progbuf_o[32*g +: 32] = r_progbuf[g];
    end

endmodule

// File: tb/tb_scr1_dm_abs_regs.sv
// tb/tb_scr1_dm_abs_regs.sv - directed self-checking bench for scr1_dm_abs_regs
module tb_scr1_dm_abs_regs;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;
    logic        cmd_req;
    logic [31:0] cmd;
    logic        ack;
    logic        done;
    logic        err;
    logic        hwe;
    logic        hsel;
    logic [31:0] hdata;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [63:0] pb;

    int n_checks = 0;
    int n_errors = 0;

    scr1_dm_abs_regs #(.PROGBUF_SIZE(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dmi2dm_req_i   (req),
        .dmi2dm_wr_i    (wr),
        .dmi2dm_addr_i  (addr),
        .dmi2dm_wdata_i (wdata),
        .dm2dmi_resp_o  (resp),
        .dm2dmi_rdata_o (rdata),
        .cmd_req_o      (cmd_req),
        .cmd_o          (cmd),
        .cmd_ack_i      (ack),
        .cmd_done_i     (done),
        .cmd_err_i      (err),
        .hart_data_we_i (hwe),
        .hart_data_sel_i(hsel),
        .hart_data_i    (hdata),
        .data0_o        (d0),
        .data1_o        (d1),
        .progbuf_o      (pb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        req = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; wr = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
        req = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        d = rdata;
        check("resp", {31'b0, resp}, 32'h1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hart_pulse(input logic a, input logic dn, input logic e);
        ack = a; done = dn; err = e;
        @(posedge clk); #1;
        ack = 1'b0; done = 1'b0; err = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        ack = 1'b0; done = 1'b0; err = 1'b0; hwe = 1'b0; hsel = 1'b0; hdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_cmd_req", {31'b0, cmd_req}, 32'h0);
        check("rst_cmd", cmd, 32'h0);
        check("rst_data0", d0, 32'h0);
        check("rst_pb", pb[31:0] | pb[63:32], 32'h0);
        dmi_read(7'h16, v); check("abscs_rst", v, 32'h0200_0002);

        dmi_write(7'h04, 32'hDEAD_BEEF);
        check("data0_o_wr", d0, 32'hDEAD_BEEF);
        dmi_read(7'h04, v); check("data0_rd", v, 32'hDEAD_BEEF);
        dmi_write(7'h20, 32'h1111_0000);
        dmi_write(7'h21, 32'h2222_0001);
        check("pb0_o", pb[31:0], 32'h1111_0000);
        check("pb1_o", pb[63:32], 32'h2222_0001);
        dmi_read(7'h21, v); check("pb1_rd", v, 32'h2222_0001);
        dmi_read(7'h22, v); check("unmapped_rd", v, 32'h0);
        dmi_read(7'h17, v); check("cmd_rd_zero", v, 32'h0);

        hwe = 1'b1; hsel = 1'b1; hdata = 32'h5555_5555;
        idle(1); hwe = 1'b0;
        check("hart_idle_ignored", d1, 32'h0);

        // Basic command: ack after 3 cycles, hart writes data0, done later
        dmi_write(7'h17, 32'h0022_1000);
        check("launch_req", {31'b0, cmd_req}, 32'h1);
        check("launch_cmd", cmd, 32'h0022_1000);
        idle(2);
        dmi_read(7'h16, v); check("abscs_busy", v, 32'h0200_1002);
        check("req_held", {31'b0, cmd_req}, 32'h1);
        hart_pulse(1'b1, 1'b0, 1'b0);
        check("req_drop", {31'b0, cmd_req}, 32'h0);
        hwe = 1'b1; hsel = 1'b0; hdata = 32'h0000_1234;
        idle(1); hwe = 1'b0;
        check("hart_wr_d0", d0, 32'h0000_1234);
        idle(3);
        hart_pulse(1'b0, 1'b1, 1'b0);
        dmi_read(7'h16, v); check("abscs_done", v, 32'h0200_0002);
        dmi_read(7'h04, v); check("data0_hart", v, 32'h0000_1234);

        // Busy access error, ignored writes, ack+done together, W1C
        dmi_write(7'h17, 32'h0033_0000);
        dmi_write(7'h05, 32'h0000_0005);
        check("busy_d1_kept", d1, 32'h0);
        dmi_read(7'h16, v); check("abscs_busyerr", v, 32'h0200_1102);
        dmi_write(7'h17, 32'h0000_ABCD);
        check("busy_cmd_kept", cmd, 32'h0033_0000);
        hart_pulse(1'b1, 1'b1, 1'b0);
        check("ackdone_req", {31'b0, cmd_req}, 32'h0);
        dmi_read(7'h16, v); check("abscs_err1_idle", v, 32'h0200_0102);
        dmi_write(7'h16, 32'h0000_0700);
        dmi_read(7'h16, v); check("abscs_w1c", v, 32'h0200_0002);

        // Completion with exception
        dmi_write(7'h17, 32'h0000_0011);
        hart_pulse(1'b1, 1'b0, 1'b0);
        hart_pulse(1'b0, 1'b1, 1'b1);
        dmi_read(7'h16, v); check("abscs_err3", v, 32'h0200_0302);
        dmi_write(7'h17, 32'h0000_0022);
        check("err_no_launch", {31'b0, cmd_req}, 32'h0);
        check("err_cmd_kept", cmd, 32'h0000_0011);
        dmi_write(7'h16, 32'h0000_0300);
        dmi_read(7'h16, v); check("abscs_clr3", v, 32'h0200_0002);

        // Autoexec on data0 read
        dmi_write(7'h18, 32'hFFFF_FFFD);
        dmi_read(7'h18, v); check("auto_rd", v, 32'h0000_0001);
        dmi_read(7'h04, v); check("auto_d0_rd", v, 32'h0000_1234);
        check("auto_req", {31'b0, cmd_req}, 32'h1);
        check("auto_cmd", cmd, 32'h0000_0011);
        hart_pulse(1'b1, 1'b1, 1'b0);
        check("auto_ackdone", {31'b0, cmd_req}, 32'h0);
        dmi_read(7'h16, v); check("auto_idle", v, 32'h0200_0002);

        // Reset asserted mid-REQ
        dmi_read(7'h04, v);
        check("auto_req2", {31'b0, cmd_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'b0, cmd_req}, 32'h0);
        check("mid_rst_cmd", cmd, 32'h0);
        check("mid_rst_d0", d0, 32'h0);
        check("mid_rst_pb", pb[31:0] | pb[63:32], 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        hart_pulse(1'b1, 1'b1, 1'b1);
        check("post_rst_req", {31'b0, cmd_req}, 32'h0);
        dmi_read(7'h16, v); check("post_rst_abscs", v, 32'h0200_0002);
        dmi_read(7'h18, v); check("post_rst_auto", v, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
